// File: rtl/v_store_sequencer_pkg.sv
// Shared types, op codes and sizing helpers for the vector store sequencer.
// Element width comes from the op; register count comes from lmul.
package v_store_sequencer_pkg;

  localparam int VLEN   = 128;
  localparam int NLANE  = 4;
  localparam int DATA_W = 4 * VLEN;

  localparam logic [5:0] SEW_8  = 6'd8;
  localparam logic [5:0] SEW_16 = 6'd16;
  localparam logic [5:0] SEW_32 = 6'd32;

  localparam logic [3:0] VLSU_VSE8   = 4'h1;
  localparam logic [3:0] VLSU_VSE16  = 4'h2;
  localparam logic [3:0] VLSU_VSE32  = 4'h3;
  localparam logic [3:0] VLSU_VSSE8  = 4'h5;
  localparam logic [3:0] VLSU_VSSE16 = 4'h6;
  localparam logic [3:0] VLSU_VSSE32 = 4'h7;

  typedef enum logic [1:0] {VSQ_IDLE, VSQ_STORE, VSQ_DONE} vsq_state_t;

  function automatic logic [2:0] vsq_nreg(input logic [2:0] lmul);
    case (lmul)
      3'b001:  return 3'd2;
      3'b010:  return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic vsq_op_valid(input logic [3:0] op);
    return (op == VLSU_VSE8)  || (op == VLSU_VSE16)  || (op == VLSU_VSE32) ||
           (op == VLSU_VSSE8) || (op == VLSU_VSSE16) || (op == VLSU_VSSE32);
  endfunction

  function automatic logic vsq_op_strided(input logic [3:0] op);
    return (op == VLSU_VSSE8) || (op == VLSU_VSSE16) || (op == VLSU_VSSE32);
  endfunction

  function automatic logic [5:0] vsq_sew(input logic [3:0] op);
    case (op)
      VLSU_VSE16, VLSU_VSSE16: return SEW_16;
      VLSU_VSE32, VLSU_VSSE32: return SEW_32;
      default:                 return SEW_8;
    endcase
  endfunction

  // Index of the final beat: (VLEN/SEW)*NREG/4 - 1, at most 15.
  function automatic logic [3:0] vsq_last_beat(input logic [5:0] sew, input logic [2:0] nreg);
    logic [4:0] beats;
    case (sew)
      SEW_8:   beats = 5'(nreg) << 2;
      SEW_16:  beats = 5'(nreg) << 1;
      default: beats = 5'(nreg);
    endcase
    return 4'(beats - 5'd1);
  endfunction

endpackage

// File: rtl/v_store_sequencer_if.sv
// Issue-side request and bank-side write ports of the store sequencer.
// start/ready: a request transfers on a clock edge where start=1 and ready=1; start while ready=0 is dropped.
interface v_store_sequencer_if
  import v_store_sequencer_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int STRIDE_W = 5
) ();

  logic                            start;
  logic                            ready;
  logic [3:0]                      store_op;
  logic [2:0]                      lmul;
  logic [2:0]                      vsew;
  logic [STRIDE_W-1:0]             stride;
  logic [ADDR_W-1:0]               address;
  logic [DATA_W-1:0]               data;
  logic [NLANE-1:0][ADDR_W-1:0]    bank_addr;
  logic [NLANE-1:0][31:0]          bank_data;
  logic [NLANE-1:0]                bank_we;
  logic                            busy;
  logic                            done;

  modport master (
    output start, store_op, lmul, vsew, stride, address, data,
    input  ready, bank_addr, bank_data, bank_we, busy, done
  );

  modport slave (
    input  start, store_op, lmul, vsew, stride, address, data,
    output ready, bank_addr, bank_data, bank_we, busy, done
  );

endinterface

// File: rtl/v_store_sequencer_lane.sv
// One bank lane: picks element elem from the snapshot, sign-extends it to 32 bits
// and forms its word address (unit-stride or strided, wrapping at 2^ADDR_W).
module v_store_sequencer_lane
  import v_store_sequencer_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int STRIDE_W = 5
) (
  input  logic [DATA_W-1:0]   data,
  input  logic [5:0]          elem,
  input  logic [5:0]          sew,
  input  logic                strided,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [ADDR_W-1:0]   base,
  output logic [31:0]         wdata,
  output logic [ADDR_W-1:0]   waddr
);

  logic [7:0]  e8;
  logic [15:0] e16;
  logic [10:0] offset;

  assign e8  = data[{elem, 3'b000} +: 8];
  assign e16 = data[{elem[4:0], 4'b0000} +: 16];

  always_comb begin
    wdata = '0;
    case (sew)
      SEW_8:   wdata = {{24{e8[7]}}, e8};
      SEW_16:  wdata = {{16{e16[15]}}, e16};
      default: wdata = data[{elem[3:0], 5'b00000} +: 32];
    endcase
  end

  // 63 * 31 still fits in 11 bits, so the product never overflows before the wrap.
  assign offset = strided ? 11'(elem) * 11'(stride) : 11'(elem);
  assign waddr  = base + ADDR_W'(offset);

endmodule

// File: rtl/v_store_sequencer.sv
// Sequences one vector store from a latched register-group snapshot into four
// 32-bit banks, one element per bank per beat; bank ports are registered.
module v_store_sequencer
  import v_store_sequencer_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int STRIDE_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  v_store_sequencer_if.slave   bus,
  output vsq_state_t           dbg_state
);

  vsq_state_t state, state_next;
  logic       accept, advance, op_ok, idle;
  logic       ready_c, busy_c, done_c;

  logic [DATA_W-1:0]   data_q;
  logic [5:0]          sew_q;
  logic                strided_q;
  logic [STRIDE_W-1:0] stride_q;
  logic [ADDR_W-1:0]   base_q;
  logic [3:0]          last_q, beat_q;

  logic [NLANE-1:0]             we_q;
  logic [NLANE-1:0][ADDR_W-1:0] addr_q;
  logic [NLANE-1:0][31:0]       wdata_q;

  logic [DATA_W-1:0]            src_data;
  logic [5:0]                   src_sew;
  logic                         src_strided;
  logic [STRIDE_W-1:0]          src_stride;
  logic [ADDR_W-1:0]            src_base;
  logic [3:0]                   src_beat;
  logic [NLANE-1:0][ADDR_W-1:0] lane_addr;
  logic [NLANE-1:0][31:0]       lane_data;

  assign op_ok = vsq_op_valid(bus.store_op);
  assign idle  = (state == VSQ_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= VSQ_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    ready_c    = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      VSQ_IDLE: begin
        ready_c = 1'b1;
        if (bus.start) begin
          accept     = 1'b1;
          state_next = op_ok ? VSQ_STORE : VSQ_DONE;
        end
      end
      VSQ_STORE: begin
        busy_c = 1'b1;
        if (beat_q == last_q) state_next = VSQ_DONE;
        else                  advance    = 1'b1;
      end
      VSQ_DONE: begin
        busy_c     = 1'b1;
        done_c     = 1'b1;
        state_next = VSQ_IDLE;
      end
      default: state_next = VSQ_IDLE;
    endcase
  end

  // Beat 0 is built straight from the request so it lands in the first STORE cycle;
  // later beats come from the latched snapshot.
  assign src_data    = idle ? bus.data : data_q;
  assign src_sew     = idle ? vsq_sew(bus.store_op) : sew_q;
  assign src_strided = idle ? vsq_op_strided(bus.store_op) : strided_q;
  assign src_stride  = idle ? bus.stride : stride_q;
  assign src_base    = idle ? bus.address : base_q;
  assign src_beat    = idle ? 4'd0 : beat_q + 4'd1;

  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    v_store_sequencer_lane #(.ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)) u_lane (
      .data    (src_data),
      .elem    ({src_beat, 2'(k)}),
      .sew     (src_sew),
      .strided (src_strided),
      .stride  (src_stride),
      .base    (src_base),
      .wdata   (lane_data[k]),
      .waddr   (lane_addr[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      sew_q     <= '0;
      strided_q <= 1'b0;
      stride_q  <= '0;
      base_q    <= '0;
      last_q    <= '0;
      beat_q    <= '0;
      we_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else if (accept && op_ok) begin
      data_q    <= bus.data;
      sew_q     <= vsq_sew(bus.store_op);
      strided_q <= vsq_op_strided(bus.store_op);
      stride_q  <= bus.stride;
      base_q    <= bus.address;
      last_q    <= vsq_last_beat(vsq_sew(bus.store_op), vsq_nreg(bus.lmul));
      beat_q    <= 4'd0;
      we_q      <= '1;
      addr_q    <= lane_addr;
      wdata_q   <= lane_data;
    end else if (advance) begin
      beat_q    <= src_beat;
      we_q      <= '1;
      addr_q    <= lane_addr;
      wdata_q   <= lane_data;
    end else begin
      we_q      <= '0;
    end
  end

  assign bus.ready     = ready_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.bank_we   = we_q;
  assign bus.bank_addr = addr_q;
  assign bus.bank_data = wdata_q;
  assign dbg_state     = state;

endmodule
